bitwise_logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit generalising the single 2-input XOR cell to a WIDTH-bit, 8-operation datapath with valid/ready handshake and result flags. It serves as the logic-op slice of the RV32I ALU (AND/OR/XOR and derivatives) and as a reusable LogicBlocks element. Throughput is one operation per cycle. Latency is STAGES cycles under no backpressure.

---
 rtl/logic_ops_pkg.sv | 17 +
 rtl/bitwise_logic_core.sv | 39 +++
 rtl/bitwise_logic_pipe.sv | 112 +++++++++++
 tb/tb_bitwise_logic_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_ops_pkg.sv
// Shared op-code definitions for the bitwise logic slice and the ALU decoder.
package logic_ops_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_XNOR   = 3'b011,
        OP_NAND   = 3'b100,
        OP_NOR    = 3'b101,
        OP_ANDN   = 3'b110,
        OP_PASS_A = 3'b111
    } logic_op_e;

endpackage

// File: rtl/bitwise_logic_core.sv
// Purely combinational WIDTH-bit logic unit: result plus zero and odd-parity flags.
module bitwise_logic_core
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    // Odd parity: 1 when the number of set bits is odd.
    function automatic logic odd_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Decode the op select into the bitwise result.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (logic_op_e'(op))
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_XNOR:   result = ~(a ^ b);
            OP_NAND:   result = ~(a & b);
            OP_NOR:    result = ~(a | b);
            OP_ANDN:   result = a & ~b;
            OP_PASS_A: result = a;
            default:   result = a;
        endcase
    end

    assign zero   = (result == {WIDTH{1'b0}});
    assign parity = odd_parity(result);

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshake. The core result and
// flags are captured into stage 1 and carried unchanged through STAGES
// register stages; empty stages fill even while the output is stalled.
module bitwise_logic_pipe
    import logic_ops_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity
);

    // Payload layout: {parity, zero, result}.
    localparam int PW = WIDTH + 2;

    logic [WIDTH-1:0] core_result_s;
    logic             core_zero_s;
    logic             core_parity_s;

    logic [PW-1:0]    pay_s [0:STAGES];
    logic [STAGES:1]  v_s;
    logic [STAGES:1]  adv_s;
    logic             in_ready_s;
    logic             in_xfer_s;

    bitwise_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (core_result_s),
        .zero   (core_zero_s),
        .parity (core_parity_s)
    );

    assign pay_s[0] = {core_parity_s, core_zero_s, core_result_s};

    // Ready chain: a stage advances when the next stage is empty or advancing.
    always_comb begin
        logic chain_v;
        chain_v = out_ready;
        adv_s   = '0;
        for (int k = STAGES; k >= 1; k--) begin
            adv_s[k] = chain_v;
            chain_v  = !v_s[k] || chain_v;
        end
        in_ready_s = chain_v;
    end

    assign in_xfer_s = in_valid && in_ready_s;

    for (genvar g = 1; g <= STAGES; g++) begin : g_stage
        logic          v_q;
        logic          v_d;
        logic          load_s;
        logic [PW-1:0] pay_q;
        logic [PW-1:0] pay_d;

        if (g == 1) begin : g_first
            assign load_s = in_xfer_s;
        end else begin : g_next
            assign load_s = v_s[g-1] && adv_s[g-1];
        end

        // Load from predecessor, drain when advancing with nothing behind, else hold.
        always_comb begin
            v_d   = v_q;
            pay_d = pay_q;
            if (load_s) begin
                v_d   = 1'b1;
                pay_d = pay_s[g-1];
            end else if (adv_s[g]) begin
                v_d = 1'b0;
            end else begin
                v_d = v_q;
            end
        end

        // Stage register with asynchronous clear of valid and payload.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                pay_q <= '0;
            end else begin
                v_q   <= v_d;
                pay_q <= pay_d;
            end
        end

        assign v_s[g]   = v_q;
        assign pay_s[g] = pay_q;
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = v_s[STAGES];
    assign out_result = pay_s[STAGES][WIDTH-1:0];
    assign out_zero   = pay_s[STAGES][WIDTH];
    assign out_parity = pay_s[STAGES][WIDTH+1];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: scoreboard queue of expected
// results, one task per scenario, a 32-bit/2-stage DUT and a 1-bit/4-stage DUT.
module tb_bitwise_logic_pipe;

    localparam int W = 32;
    localparam int S = 2;
    localparam int S1 = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         p;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_parity;

    logic         w_in_valid;
    logic         w_in_ready;
    logic [2:0]   w_in_op;
    logic [0:0]   w_in_a;
    logic [0:0]   w_in_b;
    logic         w_out_valid;
    logic         w_out_ready;
    logic [0:0]   w_out_result;
    logic         w_out_zero;
    logic         w_out_parity;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    exp_t exp_q [$];
    int   cyc_q [$];

    logic [W-1:0] sweep_tbl [8] = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h00FF_1234,
                                    32'hFF0F_EDCB, 32'h000F_0000, 32'hF000_0000, 32'hF0F0_1234};

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_parity(out_parity)
    );

    bitwise_logic_pipe #(.WIDTH(1), .STAGES(S1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_op(w_in_op), .in_a(w_in_a), .in_b(w_in_b), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_result(w_out_result), .out_zero(w_out_zero),
        .out_parity(w_out_parity)
    );

    // Reference model of the logic operations.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        case (op)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd2: e.r = a ^ b;
            3'd3: e.r = a ~^ b;
            3'd4: e.r = ~(a & b);
            3'd5: e.r = ~(a | b);
            3'd6: e.r = a & ~b;
            default: e.r = a;
        endcase
        e.z = (e.r == 32'h0);
        e.p = ($countones(e.r) % 2) == 1;
        return e;
    endfunction

    // One clock: sample just after the falling edge, update the scoreboard,
    // then wait for the next falling edge. Comparisons stay with the caller.
    task automatic tick(output logic fired, output logic have_e, output exp_t e,
                        output exp_t obs, output int lat, output logic accepted);
        #1;
        fired    = out_valid && out_ready;
        accepted = in_valid && in_ready;
        obs.r    = out_result;
        obs.z    = out_zero;
        obs.p    = out_parity;
        have_e   = 1'b0;
        e        = '0;
        lat      = -1;
        if (fired && exp_q.size() != 0) begin
            e      = exp_q.pop_front();
            lat    = cyc - cyc_q.pop_front();
            have_e = 1'b1;
        end
        if (accepted) begin
            exp_q.push_back(model(in_op, in_a, in_b));
            cyc_q.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_op = 3'd2; w_in_a = 1'b0; w_in_b = 1'b0; w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_zero !== 1'b0 ||
            out_parity !== 1'b0 || in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_in_ready !== 1'b1)
            $display("FAIL reset: got v=%b r=%h z=%b p=%b rdy=%b w_v=%b w_rdy=%b required 0 0 0 0 1 0 1",
                     out_valid, out_result, out_zero, out_parity, in_ready, w_out_valid, w_in_ready);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_op_sweep();
        logic fired, have_e, acc; exp_t e, obs; int lat; int n;
        n = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; in_op = i[2:0]; in_a = 32'hF0F0_1234; in_b = 32'h0FF0_FFFF;
            end else begin
                in_valid = 1'b0;
            end
            tick(fired, have_e, e, obs, lat, acc);
            if (fired && n < 8) begin
                total_cnt++;
                if (!have_e || obs.r !== sweep_tbl[n] || obs.z !== 1'b0 ||
                    obs.p !== (^sweep_tbl[n]) || lat != S)
                    $display("FAIL op_sweep[%0d]: got r=%h z=%b p=%b lat=%0d required r=%h z=0 p=%b lat=%0d",
                             n, obs.r, obs.z, obs.p, lat, sweep_tbl[n], ^sweep_tbl[n], S);
                else pass_cnt++;
                n++;
            end
        end
        total_cnt++;
        if (n != 8) $display("FAIL op_sweep_count: got %0d results required 8", n);
        else pass_cnt++;
    endtask

    task automatic test_flags();
        logic fired, have_e, acc; exp_t e, obs; int lat; int n;
        logic [W-1:0] er [2]; logic ez [2]; logic ep [2];
        er[0] = 32'h0; ez[0] = 1'b1; ep[0] = 1'b0;
        er[1] = 32'h1; ez[1] = 1'b0; ep[1] = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 2);
            if (i == 0) begin in_op = 3'd2; in_a = 32'hDEAD_BEEF; in_b = 32'hDEAD_BEEF; end
            if (i == 1) begin in_op = 3'd0; in_a = 32'h0000_0001; in_b = 32'hFFFF_FFFF; end
            tick(fired, have_e, e, obs, lat, acc);
            if (fired && n < 2) begin
                total_cnt++;
                if (obs.r !== er[n] || obs.z !== ez[n] || obs.p !== ep[n])
                    $display("FAIL flags[%0d]: got r=%h z=%b p=%b required r=%h z=%b p=%b",
                             n, obs.r, obs.z, obs.p, er[n], ez[n], ep[n]);
                else pass_cnt++;
                n++;
            end
        end
        total_cnt++;
        if (n != 2) $display("FAIL flags_count: got %0d results required 2", n);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic fired, have_e, acc; exp_t e, obs; int lat; int k, got;
        logic [W-1:0] va [5]; logic [W-1:0] vb [5]; logic [2:0] vo [5];
        logic [W-1:0] held; logic held_set;
        for (int i = 0; i < 5; i++) begin
            va[i] = $urandom; vb[i] = $urandom; vo[i] = 3'($urandom_range(0, 7));
        end
        k = 0; got = 0; held = '0; held_set = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_op = vo[k]; in_a = va[k]; in_b = vb[k];
            tick(fired, have_e, e, obs, lat, acc);
            if (acc) k++;
            if (out_valid) begin
                if (!held_set) begin
                    held = out_result; held_set = 1'b1;
                end else begin
                    total_cnt++;
                    if (out_result !== held)
                        $display("FAIL stall_stable: got %h required %h", out_result, held);
                    else pass_cnt++;
                end
            end
        end
        #1;
        total_cnt++;
        if (k != S || in_ready !== 1'b0)
            $display("FAIL bp_full: got accepts=%0d in_ready=%b required accepts=%0d in_ready=0", k, in_ready, S);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (k < 5);
            if (k < 5) begin in_op = vo[k]; in_a = va[k]; in_b = vb[k]; end
            tick(fired, have_e, e, obs, lat, acc);
            if (acc) k++;
            if (fired) begin
                total_cnt++;
                if (!have_e || obs !== e)
                    $display("FAIL bp_drain[%0d]: got r=%h z=%b p=%b required r=%h z=%b p=%b",
                             got, obs.r, obs.z, obs.p, e.r, e.z, e.p);
                else pass_cnt++;
                got++;
            end
        end
        total_cnt++;
        if (got != 5 || exp_q.size() != 0)
            $display("FAIL bp_count: got %0d results (%0d pending) required 5 (0 pending)", got, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic fired, have_e, acc; exp_t e, obs; int lat; int acc_n, bad, occ_bad, cyc_n;
        acc_n = 0; bad = 0; occ_bad = 0; cyc_n = 0;
        while ((acc_n < 1000 || exp_q.size() != 0) && cyc_n < 8000) begin
            in_valid  = (acc_n < 1000) && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_op = 3'($urandom_range(0, 7)); in_a = $urandom; in_b = $urandom;
            #1;
            if (!in_ready && (exp_q.size() != S || out_ready)) begin
                occ_bad++;
                if (occ_bad < 5)
                    $display("FAIL rand_stall: got in_ready=0 with %0d in flight out_ready=%b required %0d and 0",
                             exp_q.size(), out_ready, S);
            end
            tick(fired, have_e, e, obs, lat, acc);
            if (acc) acc_n++;
            if (fired) begin
                total_cnt++;
                if (!have_e || obs !== e) begin
                    bad++;
                    if (bad < 5)
                        $display("FAIL rand_result: got r=%h z=%b p=%b required r=%h z=%b p=%b",
                                 obs.r, obs.z, obs.p, e.r, e.z, e.p);
                end else pass_cnt++;
            end
            cyc_n++;
        end
        total_cnt++;
        if (acc_n != 1000 || exp_q.size() != 0 || occ_bad != 0)
            $display("FAIL rand_done: got %0d accepted %0d pending %0d bad stalls required 1000 0 0",
                     acc_n, exp_q.size(), occ_bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic fired, have_e, acc; exp_t e, obs; int lat; int stale, got;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i < 2); in_op = 3'd1; in_a = 32'h1234_0000 + 32'(i); in_b = 32'h0000_00F0;
            tick(fired, have_e, e, obs, lat, acc);
        end
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL mid_loaded: got out_valid=%b required 1", out_valid);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_result !== 32'h0)
            $display("FAIL mid_reset: got v=%b r=%h required v=0 r=0", out_valid, out_result);
        else pass_cnt++;
        exp_q.delete(); cyc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick(fired, have_e, e, obs, lat, acc);
            if (fired) stale++;
        end
        total_cnt++;
        if (stale != 0) $display("FAIL mid_stale: got %0d stale results required 0", stale);
        else pass_cnt++;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i == 0); in_op = 3'd6; in_a = 32'hFFFF_0000; in_b = 32'h0F0F_0F0F;
            tick(fired, have_e, e, obs, lat, acc);
            if (fired) begin
                total_cnt++;
                if (!have_e || obs.r !== 32'hF0F0_0000)
                    $display("FAIL mid_after: got r=%h required r=f0f00000", obs.r);
                else pass_cnt++;
                got++;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (got != 1) $display("FAIL mid_after_count: got %0d required 1", got);
        else pass_cnt++;
    endtask

    task automatic test_width1_xor();
        logic xor_tbl [4]; logic bit_q [$]; logic eb; int got;
        xor_tbl[0] = 1'b0; xor_tbl[1] = 1'b1; xor_tbl[2] = 1'b1; xor_tbl[3] = 1'b0;
        got = 0;
        w_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w_in_valid = (i < 4); w_in_op = 3'd2;
            w_in_a = 1'(i >> 1); w_in_b = 1'(i);
            #1;
            if (w_out_valid && w_out_ready) begin
                total_cnt++;
                eb = (bit_q.size() != 0) ? bit_q.pop_front() : ~w_out_result[0];
                if (w_out_result[0] !== eb || w_out_zero !== ~eb || w_out_parity !== eb)
                    $display("FAIL w1_xor[%0d]: got r=%b z=%b p=%b required r=%b z=%b p=%b",
                             got, w_out_result[0], w_out_zero, w_out_parity, eb, ~eb, eb);
                else pass_cnt++;
                got++;
            end
            if (w_in_valid && w_in_ready) bit_q.push_back(xor_tbl[i]);
            @(negedge clk);
        end
        w_in_valid = 1'b0;
        total_cnt++;
        if (got != 4) $display("FAIL w1_count: got %0d results required 4", got);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_flags();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_width1_xor();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
